// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Controller state and architectural register constants.
package pipe_ctrl_pkg;

    typedef enum logic {RUN, MWAIT} pc_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush outputs between the
// pipeline datapath (master) and its sequencer (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             mem_rdE;
    logic [4:0]       waddrE;
    logic [4:0]       raddr1D;
    logic [4:0]       raddr2D;
    logic             use1D;
    logic             use2D;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             perf_clr;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output mem_rdE, waddrE, raddr1D, raddr2D,
        output use1D, use2D, br_taken,
        output mem_req, mem_ack, perf_clr,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  mem_rdE, waddrE, raddr1D, raddr2D,
        input  use1D, use2D, br_taken,
        input  mem_req, mem_ack, perf_clr,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW,
        output mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare between Execute and Decode.
// A load into x0 never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_rdE,
    input  logic [4:0] waddrE,
    input  logic [4:0] raddr1D,
    input  logic [4:0] raddr2D,
    input  logic       use1D,
    input  logic       use2D,
    output logic       hazard
);

    // Decode reads a register the load in Execute is writing
    always_comb begin
        hazard = mem_rdE
               && (waddrE != REG_X0)
               && ((use1D && (waddrE == raddr1D))
                || (use2D && (waddrE == raddr2D)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: memory wait, branch flush,
// load-use stall, plus saturating performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    pc_state_t        state;
    pc_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic             lu_hit;
    logic             tmo;
    logic             mem_stall;
    logic             br_flush;
    logic             err_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    load_use_detect u_lud (
        .mem_rdE (bus.mem_rdE),
        .waddrE  (bus.waddrE),
        .raddr1D (bus.raddr1D),
        .raddr2D (bus.raddr2D),
        .use1D   (bus.use1D),
        .use2D   (bus.use2D),
        .hazard  (lu_hit)
    );

    // A wait that runs out of budget is released like an ack
    always_comb begin
        tmo = (state == MWAIT) && (wait_cnt == WAIT_LAST)
            && bus.mem_req && !bus.mem_ack;
        mem_stall = bus.mem_req && !bus.mem_ack && !tmo;
        br_flush  = !mem_stall && bus.br_taken;
    end

    // Next state and prioritised stall/flush decode
    always_comb begin
        state_nxt  = state;
        bus.stallF = 1'b0;
        bus.stallD = 1'b0;
        bus.stallE = 1'b0;
        bus.stallM = 1'b0;
        bus.flushD = 1'b0;
        bus.flushE = 1'b0;
        bus.flushW = 1'b0;
        if (!rst) begin
            state_nxt  = RUN;
            bus.flushD = 1'b1;
            bus.flushE = 1'b1;
        end else if (mem_stall) begin
            state_nxt  = MWAIT;
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            bus.stallM = 1'b1;
            bus.flushW = 1'b1;
        end else begin
            state_nxt = RUN;
            if (bus.br_taken) begin
                bus.flushD = 1'b1;
                bus.flushE = 1'b1;
            end else if (lu_hit) begin
                bus.stallF = 1'b1;
                bus.stallD = 1'b1;
                bus.flushE = 1'b1;
            end
        end
    end

    // State, wait counter and timeout error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_q    <= tmo;
            if ((state == MWAIT) && mem_stall)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Saturating counters, clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.perf_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (bus.stallF && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (br_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.mem_err   = err_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule
